keypad_entry_ctrl: RTL and testbench

- Sequences decoded keypad events (4-bit hex code plus one-cycle valid pulse from the keypad scanner) into multi-digit hex entries.
- Supports digit accumulation, clear, enter and inactivity timeout.
- Completed entries go to a downstream consumer (lock/compare logic, register loader) over a valid/ready handshake.
- Exports the live entry buffer for seven-segment display.

---
 rtl/keypad_entry_ctrl_pkg.sv | 23 ++
 rtl/keypad_entry_ctrl_timer.sv | 34 +++
 rtl/keypad_entry_ctrl.sv | 155 +++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared constants for the keypad entry controller: key codes, state encoding
// and the digit-count width helper.
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ENTRY = ST_ENTRY,
        S_HOLD  = ST_HOLD
    } state_e;

    // Bits needed to hold a digit count in 0..max_digits.
    function automatic int cnt_width(input int max_digits);
        return $clog2(max_digits + 1);
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_timer.sv
// Inactivity counter: clears on clr, counts on en, flags the last cycle
// before LIMIT idle cycles have elapsed.
module entry_timer #(
    parameter int unsigned LIMIT = 500_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [31:0] cnt_q, cnt_d;

    // Next count: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 32'd1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == 32'(LIMIT - 1));

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Turns single-cycle keypad events into multi-digit hex entries, with clear,
// enter, inactivity timeout and a valid/ready hand-off of committed values.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int          MAX_DIGITS     = 4,
    parameter logic [3:0]  ENTER_KEY      = KEY_ENTER,
    parameter logic [3:0]  CLEAR_KEY      = KEY_CLEAR,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    localparam int         W              = 4 * MAX_DIGITS,
    localparam int         CW             = cnt_width(MAX_DIGITS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    key,
    input  logic          key_valid,
    input  logic          value_ready,
    output logic [W-1:0]  value_out,
    output logic [CW-1:0] value_digits,
    output logic          value_valid,
    output logic [W-1:0]  entry_buf,
    output logic [CW-1:0] entry_count,
    output logic          entry_active,
    output logic          entry_err,
    output logic          timeout
);

    state_e        state_q, state_d;
    logic [W-1:0]  buf_q, buf_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  vout_q, vout_d;
    logic [CW-1:0] vdig_q, vdig_d;
    logic          vvalid_q, vvalid_d;
    logic          err_q, err_d;
    logic          to_q, to_d;

    logic tmr_clr, tmr_en, tmr_expire;
    logic is_enter, is_clear, is_digit;

    assign is_enter = (key == ENTER_KEY);
    assign is_clear = (key == CLEAR_KEY);
    assign is_digit = !is_enter && !is_clear;

    entry_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    // Next-state and datapath: timer is held clear everywhere except while
    // idling inside ENTRY, so it never counts in IDLE or HOLD.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        count_d  = count_q;
        vout_d   = vout_q;
        vdig_d   = vdig_q;
        vvalid_d = vvalid_q;
        err_d    = 1'b0;
        to_d     = 1'b0;
        tmr_clr  = 1'b1;
        tmr_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    if (is_enter) begin
                        err_d = 1'b1;
                    end else if (is_digit) begin
                        buf_d   = W'(key);
                        count_d = CW'(1);
                        state_d = S_ENTRY;
                    end
                end
            end

            S_ENTRY: begin
                if (key_valid) begin
                    // A key in the expiry cycle wins over the timeout.
                    if (is_enter) begin
                        vout_d   = buf_q;
                        vdig_d   = count_q;
                        vvalid_d = 1'b1;
                        buf_d    = '0;
                        count_d  = '0;
                        state_d  = S_HOLD;
                    end else if (is_clear) begin
                        buf_d   = '0;
                        count_d = '0;
                        state_d = S_IDLE;
                    end else if (count_q < CW'(MAX_DIGITS)) begin
                        buf_d   = (buf_q << 4) | W'(key);
                        count_d = count_q + CW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmr_expire) begin
                    buf_d   = '0;
                    count_d = '0;
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
            end

            S_HOLD: begin
                if (key_valid)
                    err_d = 1'b1;
                if (vvalid_q && value_ready) begin
                    vvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset discards any pending value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            buf_q    <= '0;
            count_q  <= '0;
            vout_q   <= '0;
            vdig_q   <= '0;
            vvalid_q <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            count_q  <= count_d;
            vout_q   <= vout_d;
            vdig_q   <= vdig_d;
            vvalid_q <= vvalid_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

    assign value_out    = vout_q;
    assign value_digits = vdig_q;
    assign value_valid  = vvalid_q;
    assign entry_buf    = buf_q;
    assign entry_count  = count_q;
    assign entry_active = (state_q == S_ENTRY);
    assign entry_err    = err_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus randomized traffic
// against a digit-queue reference model.
module tb_keypad_entry_ctrl;

    localparam int MD = 4;
    localparam int TO = 50;
    localparam int W  = 4 * MD;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    key = 4'h0;
    logic          key_valid = 1'b0;
    logic          value_ready = 1'b0;
    logic [W-1:0]  value_out;
    logic [CW-1:0] value_digits;
    logic          value_valid;
    logic [W-1:0]  entry_buf;
    logic [CW-1:0] entry_count;
    logic          entry_active;
    logic          entry_err;
    logic          timeout;

    keypad_entry_ctrl #(
        .MAX_DIGITS     (MD),
        .ENTER_KEY      (4'hE),
        .CLEAR_KEY      (4'hF),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key          (key),
        .key_valid    (key_valid),
        .value_ready  (value_ready),
        .value_out    (value_out),
        .value_digits (value_digits),
        .value_valid  (value_valid),
        .entry_buf    (entry_buf),
        .entry_count  (entry_count),
        .entry_active (entry_active),
        .entry_err    (entry_err),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the entry is a queue of digits; a pending value is a
    // flag plus its captured digits; idle counts key-free cycles with digits held.
    int           q[$];
    bit           m_pend;
    logic [W-1:0] m_vout;
    int           m_vdig;
    bit           m_err, m_to;
    int           m_idle;

    function automatic logic [W-1:0] qbuf();
        logic [W-1:0] v = '0;
        foreach (q[i]) v = (v << 4) | W'(q[i]);
        return v;
    endfunction

    function automatic void model_step(bit kv, logic [3:0] k, bit rdy, bit rst);
        m_err = 0;
        m_to  = 0;
        if (rst) begin
            q.delete(); m_pend = 0; m_vout = '0; m_vdig = 0; m_idle = 0;
            return;
        end
        if (m_pend) begin
            if (kv) m_err = 1;
            if (rdy) m_pend = 0;
        end else if (q.size() == 0) begin
            if (kv && k == 4'hE) m_err = 1;
            else if (kv && k != 4'hF) begin q.push_back(int'(k)); m_idle = 0; end
        end else if (kv) begin
            m_idle = 0;
            if (k == 4'hE) begin
                m_pend = 1; m_vout = qbuf(); m_vdig = q.size(); q.delete();
            end else if (k == 4'hF) q.delete();
            else if (q.size() < MD) q.push_back(int'(k));
            else m_err = 1;
        end else begin
            m_idle++;
            if (m_idle == TO) begin m_to = 1; q.delete(); m_idle = 0; end
        end
    endfunction

    // One clock: drive on the falling edge, advance the model with the
    // rising edge, leave outputs settled 1 time unit later.
    task automatic cycle(input bit kv, input logic [3:0] k, input bit rdy, input bit rst);
        @(negedge clk);
        key_valid = kv; key = k; value_ready = rdy; reset = rst;
        @(posedge clk);
        model_step(kv, k, rdy, rst);
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 4'h0, 0, 1);
        n_cmp++; if (value_valid !== 1'b0 || entry_count !== '0 || entry_err !== 1'b0 || timeout !== 1'b0) begin
            n_bad++; $display("FAIL reset_state: valid=%b cnt=%0d err=%b to=%b required all 0", value_valid, entry_count, entry_err, timeout); end
        cycle(0, 4'h0, 0, 0);
        cycle(1, 4'h1, 0, 0);
        cycle(1, 4'h2, 0, 0);
        n_cmp++; if (entry_buf !== 16'h0012 || entry_count !== 3'd2) begin
            n_bad++; $display("FAIL pre_reset_buf: buf=%h cnt=%0d required 0012/2", entry_buf, entry_count); end
        cycle(0, 4'h0, 0, 1);
        n_cmp++; if (entry_count !== '0 || entry_buf !== '0 || entry_active !== 1'b0 || value_valid !== 1'b0 || entry_err !== 1'b0 || timeout !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_entry: cnt=%0d buf=%h act=%b valid=%b err=%b to=%b required all 0",
                entry_count, entry_buf, entry_active, value_valid, entry_err, timeout); end
        // Reset while a committed value is waiting.
        cycle(0, 4'h0, 0, 0);
        cycle(1, 4'h1, 0, 0);
        cycle(1, 4'hE, 0, 0);
        cycle(0, 4'h0, 0, 1);
        n_cmp++; if (value_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_hold: valid=%b required 0", value_valid); end
        cycle(0, 4'h0, 0, 0);
    endtask

    task automatic test_enter_hold();
        cycle(1, 4'h1, 0, 0);
        cycle(1, 4'h2, 0, 0);
        cycle(1, 4'h3, 0, 0);
        cycle(1, 4'hE, 0, 0);
        n_cmp++; if (value_valid !== 1'b1 || value_out !== 16'h0123 || value_digits !== 3'd3) begin
            n_bad++; $display("FAIL enter_commit: valid=%b out=%h dig=%0d required 1/0123/3", value_valid, value_out, value_digits); end
        n_cmp++; if (entry_count !== '0 || entry_buf !== '0 || entry_active !== 1'b0) begin
            n_bad++; $display("FAIL enter_clears_buf: cnt=%0d buf=%h act=%b required 0/0/0", entry_count, entry_buf, entry_active); end
        for (int i = 0; i < 20; i++) begin
            cycle(0, 4'h0, 0, 0);
            n_cmp++; if (value_valid !== 1'b1 || value_out !== 16'h0123 || value_digits !== 3'd3) begin
                n_bad++; $display("FAIL hold_stable[%0d]: valid=%b out=%h dig=%0d required 1/0123/3", i, value_valid, value_out, value_digits); end
        end
        cycle(0, 4'h0, 1, 0);
        n_cmp++; if (value_valid !== 1'b0 || entry_active !== 1'b0 || entry_err !== 1'b0) begin
            n_bad++; $display("FAIL handshake: valid=%b act=%b err=%b required 0/0/0", value_valid, entry_active, entry_err); end
        cycle(0, 4'h0, 1, 0);
        n_cmp++; if (value_valid !== 1'b0) begin
            n_bad++; $display("FAIL ready_when_idle: valid=%b required 0", value_valid); end
        // Back in IDLE: a digit must open a fresh entry.
        cycle(1, 4'hA, 0, 0);
        n_cmp++; if (entry_active !== 1'b1 || entry_buf !== 16'h000A || entry_count !== 3'd1) begin
            n_bad++; $display("FAIL idle_after_hs: act=%b buf=%h cnt=%0d required 1/000a/1", entry_active, entry_buf, entry_count); end
        cycle(1, 4'hF, 0, 0);
    endtask

    task automatic test_overflow();
        int errs = 0;
        logic [3:0] ks [5] = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5};
        for (int i = 0; i < 5; i++) begin
            cycle(1, ks[i], 0, 0);
            if (entry_err === 1'b1) errs++;
        end
        n_cmp++; if (entry_err !== 1'b1 || errs != 1) begin
            n_bad++; $display("FAIL overflow_err: err=%b pulses=%0d required 1/1", entry_err, errs); end
        n_cmp++; if (entry_buf !== 16'h9876 || entry_count !== 3'd4) begin
            n_bad++; $display("FAIL overflow_buf: buf=%h cnt=%0d required 9876/4", entry_buf, entry_count); end
        cycle(1, 4'hE, 0, 0);
        n_cmp++; if (value_out !== 16'h9876 || value_digits !== 3'd4 || value_valid !== 1'b1 || entry_err !== 1'b0) begin
            n_bad++; $display("FAIL overflow_commit: out=%h dig=%0d valid=%b err=%b required 9876/4/1/0", value_out, value_digits, value_valid, entry_err); end
        cycle(0, 4'h0, 1, 0);
    endtask

    task automatic test_clear();
        cycle(1, 4'h4, 0, 0);
        cycle(1, 4'hF, 0, 0);
        n_cmp++; if (entry_buf !== '0 || entry_count !== '0 || entry_active !== 1'b0 || entry_err !== 1'b0) begin
            n_bad++; $display("FAIL clear: buf=%h cnt=%0d act=%b err=%b required 0/0/0/0", entry_buf, entry_count, entry_active, entry_err); end
        cycle(1, 4'hE, 0, 0);
        n_cmp++; if (entry_err !== 1'b1 || value_valid !== 1'b0) begin
            n_bad++; $display("FAIL enter_in_idle: err=%b valid=%b required 1/0", entry_err, value_valid); end
        cycle(0, 4'h0, 0, 0);
        n_cmp++; if (entry_err !== 1'b0 || value_valid !== 1'b0) begin
            n_bad++; $display("FAIL err_one_cycle: err=%b valid=%b required 0/0", entry_err, value_valid); end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int at = -1;
        cycle(1, 4'h7, 0, 0);
        for (int i = 1; i <= TO + 10; i++) begin
            cycle(0, 4'h0, 0, 0);
            if (timeout === 1'b1) begin pulses++; at = i; end
        end
        n_cmp++; if (pulses != 1 || at != TO) begin
            n_bad++; $display("FAIL timeout_pulse: pulses=%0d at_idle=%0d required 1 at %0d", pulses, at, TO); end
        n_cmp++; if (entry_count !== '0 || entry_active !== 1'b0) begin
            n_bad++; $display("FAIL timeout_clears: cnt=%0d act=%b required 0/0", entry_count, entry_active); end
        // Key arriving in the expiry cycle pre-empts the timeout.
        pulses = 0;
        cycle(1, 4'h7, 0, 0);
        for (int i = 1; i < TO; i++) begin
            cycle(0, 4'h0, 0, 0);
            if (timeout === 1'b1) pulses++;
        end
        cycle(1, 4'h3, 0, 0);
        if (timeout === 1'b1) pulses++;
        cycle(0, 4'h0, 0, 0);
        if (timeout === 1'b1) pulses++;
        n_cmp++; if (pulses != 0 || entry_count !== 3'd2 || entry_buf !== 16'h0073) begin
            n_bad++; $display("FAIL key_at_expiry: pulses=%0d cnt=%0d buf=%h required 0/2/0073", pulses, entry_count, entry_buf); end
        cycle(1, 4'hF, 0, 0);
    endtask

    task automatic test_hold_key();
        cycle(1, 4'h1, 0, 0);
        cycle(1, 4'hE, 0, 0);
        cycle(1, 4'h2, 0, 0);
        n_cmp++; if (entry_err !== 1'b1 || value_valid !== 1'b1 || value_out !== 16'h0001) begin
            n_bad++; $display("FAIL key_in_hold: err=%b valid=%b out=%h required 1/1/0001", entry_err, value_valid, value_out); end
        cycle(1, 4'h5, 1, 0);
        n_cmp++; if (value_valid !== 1'b0 || entry_err !== 1'b1 || entry_count !== '0 || entry_active !== 1'b0) begin
            n_bad++; $display("FAIL key_with_handshake: valid=%b err=%b cnt=%0d act=%b required 0/1/0/0", value_valid, entry_err, entry_count, entry_active); end
        cycle(0, 4'h0, 0, 0);
        n_cmp++; if (entry_err !== 1'b0) begin
            n_bad++; $display("FAIL hold_err_one_cycle: err=%b required 0", entry_err); end
    endtask

    task automatic test_random();
        int kv_pct = 30;
        bit kv, rdy, rst;
        logic [3:0] k;
        for (int n = 0; n < 4000; n++) begin
            if (n % 80 == 0) begin
                case ($urandom_range(2, 0))
                    0: kv_pct = 1;
                    1: kv_pct = 30;
                    default: kv_pct = 80;
                endcase
            end
            kv  = ($urandom_range(99, 0) < kv_pct);
            case ($urandom_range(7, 0))
                0: k = 4'hE;
                1: k = 4'hF;
                default: k = 4'($urandom_range(13, 0));
            endcase
            rdy = ($urandom_range(3, 0) == 0);
            rst = ($urandom_range(599, 0) == 0);
            cycle(kv, k, rdy, rst);
            n_cmp++; if (entry_buf !== qbuf() || entry_count !== CW'(q.size())) begin
                n_bad++; $display("FAIL rnd_buf[%0d]: buf=%h cnt=%0d required %h/%0d", n, entry_buf, entry_count, qbuf(), q.size()); end
            n_cmp++; if (entry_active !== (q.size() > 0) || value_valid !== m_pend) begin
                n_bad++; $display("FAIL rnd_state[%0d]: act=%b valid=%b required %b/%b", n, entry_active, value_valid, q.size() > 0, m_pend); end
            n_cmp++; if (entry_err !== m_err || timeout !== m_to) begin
                n_bad++; $display("FAIL rnd_pulse[%0d]: err=%b to=%b required %b/%b", n, entry_err, timeout, m_err, m_to); end
            if (m_pend) begin
                n_cmp++; if (value_out !== m_vout || value_digits !== CW'(m_vdig)) begin
                    n_bad++; $display("FAIL rnd_value[%0d]: out=%h dig=%0d required %h/%0d", n, value_out, value_digits, m_vout, m_vdig); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_enter_hold();
        test_overflow();
        test_clear();
        test_timeout();
        test_hold_key();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
